// File: rtl/decoded_instr_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | decoded_instr_queue: ID->issue entry buffer with CF cap, CSR serialisation,   |
// | and debug halt.   Revision: 1.0                                              |
// +-----------------------------------------------------------------------------+

package ariane_pkg;
  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU
  } fu_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [2:0]  trans_id;
    fu_t         fu;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        is_compressed;
    logic        valid;
  } scoreboard_entry_t;
endpackage

module decoded_instr_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MAX_CF = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          debug_req_i,
  input  ariane_pkg::scoreboard_entry_t decoded_entry_i,
  input  logic                          decoded_valid_i,
  input  logic                          decoded_is_ctrl_flow_i,
  output logic                          decoded_ack_o,
  output ariane_pkg::scoreboard_entry_t issue_entry_o,
  output logic                          issue_entry_valid_o,
  output logic                          is_ctrl_flow_o,
  input  logic                          issue_instr_ack_i,
  output logic [$clog2(DEPTH):0]        fill_count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_MAX_CF = CNT_W'(MAX_CF);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SERIAL = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  ariane_pkg::scoreboard_entry_t mem_q [DEPTH];
  logic [DEPTH-1:0]              cf_mem_q;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]              count_q, count_d, cf_count_q, cf_count_d;

  logic not_empty, in_is_csr, head_is_csr, head_is_cf, accept_ok, push, pop;

  assign not_empty   = (count_q != '0);
  assign in_is_csr   = (decoded_entry_i.fu == ariane_pkg::CSR);
  assign head_is_csr = (mem_q[rd_ptr_q].fu == ariane_pkg::CSR);
  assign head_is_cf  = cf_mem_q[rd_ptr_q];
  assign accept_ok   = (!decoded_is_ctrl_flow_i || (cf_count_q < C_MAX_CF)) &&
                       (!in_is_csr || !not_empty);

  // Accept never looks at the issue ack, so a full queue stalls even while popping.
  assign push = rst_ni && decoded_valid_i && !flush_i && (state_q == ST_RUN) &&
                (count_q < C_DEPTH) && accept_ok;

  assign issue_entry_valid_o = rst_ni && not_empty && !flush_i;
  assign pop                 = issue_entry_valid_o && issue_instr_ack_i;
  assign decoded_ack_o       = push;
  assign issue_entry_o       = (rst_ni && not_empty) ? mem_q[rd_ptr_q] : '0;
  assign is_ctrl_flow_o      = rst_ni && not_empty && head_is_cf;
  assign fill_count_o        = rst_ni ? count_q : '0;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    cf_count_d = cf_count_q + CNT_W'(push && decoded_is_ctrl_flow_i)
                            - CNT_W'(pop && head_is_cf);
    if (flush_i) begin
      state_d    = ST_RUN;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      cf_count_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (debug_req_i)          state_d = ST_HALT;
          else if (push && in_is_csr) state_d = ST_SERIAL;
        end
        ST_SERIAL: begin
          if (debug_req_i)               state_d = ST_HALT;
          else if (pop && head_is_csr)   state_d = ST_RUN;
        end
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_RUN;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      cf_count_q <= '0;
      cf_mem_q   <= '0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      cf_count_q <= cf_count_d;
      if (push) begin
        mem_q[wr_ptr_q]    <= decoded_entry_i;
        cf_mem_q[wr_ptr_q] <= decoded_is_ctrl_flow_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decoded_instr_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_decoded_instr_queue: vectors, directed sequences and random vs queue model |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+

module tb_decoded_instr_queue;
  import ariane_pkg::*;

  localparam int DEPTH  = 4;
  localparam int MAX_CF = 1;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              rst_ni, flush_i, debug_req_i, decoded_valid_i, decoded_is_ctrl_flow_i;
  logic              issue_instr_ack_i, decoded_ack_o, issue_entry_valid_o, is_ctrl_flow_o;
  scoreboard_entry_t decoded_entry_i, issue_entry_o;
  logic [CW-1:0]     fill_count_o;

  decoded_instr_queue #(.DEPTH(DEPTH), .MAX_CF(MAX_CF)) dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .flush_i                (flush_i),
    .debug_req_i            (debug_req_i),
    .decoded_entry_i        (decoded_entry_i),
    .decoded_valid_i        (decoded_valid_i),
    .decoded_is_ctrl_flow_i (decoded_is_ctrl_flow_i),
    .decoded_ack_o          (decoded_ack_o),
    .issue_entry_o          (issue_entry_o),
    .issue_entry_valid_o    (issue_entry_valid_o),
    .is_ctrl_flow_o         (is_ctrl_flow_o),
    .issue_instr_ack_i      (issue_instr_ack_i),
    .fill_count_o           (fill_count_o)
  );

  // Reference model: an ordered list of held entries plus the policy mode.
  typedef struct { scoreboard_entry_t e; bit cf; } slot_t;
  typedef enum int { M_RUN, M_SERIAL, M_HALT } mode_t;
  slot_t mq[$];
  mode_t mode = M_RUN;

  int n_cmp = 0;
  int n_bad = 0;

  logic              x_ack, x_valid, x_cf;
  scoreboard_entry_t x_entry;
  int                x_fill;

  typedef struct { bit fl; bit dbg; bit v; bit cf; bit csr; bit ack; int eack; int evalid; int efill; } vec_t;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic scoreboard_entry_t mk(input fu_t fu, input logic [63:0] pc);
    scoreboard_entry_t e;
    e               = '0;
    e.pc            = pc;
    e.trans_id      = 3'($urandom);
    e.fu            = fu;
    e.op            = 7'($urandom);
    e.rs1           = 5'($urandom);
    e.rs2           = 5'($urandom);
    e.rd            = 5'($urandom);
    e.result        = {$urandom, $urandom};
    e.is_compressed = 1'($urandom);
    e.valid         = 1'b1;
    return e;
  endfunction

  task automatic model_eval();
    int ncf;
    ncf = 0;
    foreach (mq[i]) if (mq[i].cf) ncf++;
    x_ack = 1'b0; x_valid = 1'b0; x_cf = 1'b0; x_entry = '0; x_fill = 0;
    if (rst_ni) begin
      x_fill  = mq.size();
      x_valid = (mq.size() > 0) && !flush_i;
      if (mq.size() > 0) begin
        x_entry = mq[0].e;
        x_cf    = mq[0].cf;
      end
      x_ack = decoded_valid_i && !flush_i && (mode == M_RUN) && (mq.size() < DEPTH) &&
              (!decoded_is_ctrl_flow_i || ncf < MAX_CF) &&
              (decoded_entry_i.fu != CSR || mq.size() == 0);
    end
  endtask

  task automatic model_update();
    bit popd, head_csr;
    if (!rst_ni || flush_i) begin
      mq.delete();
      mode = M_RUN;
    end else begin
      popd     = x_valid && issue_instr_ack_i;
      head_csr = popd && (mq[0].e.fu == CSR);
      case (mode)
        M_RUN:    if (debug_req_i) mode = M_HALT;
                  else if (x_ack && decoded_entry_i.fu == CSR) mode = M_SERIAL;
        M_SERIAL: if (debug_req_i) mode = M_HALT;
                  else if (head_csr) mode = M_RUN;
        default:  ;
      endcase
      if (popd) void'(mq.pop_front());
      if (x_ack) mq.push_back('{decoded_entry_i, decoded_is_ctrl_flow_i});
    end
  endtask

  // One clock cycle: drive, check against model (and optional fixed expectations), clock.
  task automatic step(input bit rstn, input bit fl, input bit dbg, input bit v, input bit cf,
                      input scoreboard_entry_t e, input bit ack,
                      input int eack, input int evalid, input int efill);
    rst_ni = rstn; flush_i = fl; debug_req_i = dbg; decoded_valid_i = v;
    decoded_is_ctrl_flow_i = cf; decoded_entry_i = e; issue_instr_ack_i = ack;
    #1;
    model_eval();
    chk("ack",   256'(decoded_ack_o),       256'(x_ack));
    chk("valid", 256'(issue_entry_valid_o), 256'(x_valid));
    chk("fill",  256'(fill_count_o),        256'(x_fill));
    chk("cf",    256'(is_ctrl_flow_o),      256'(x_cf));
    chk("entry", 256'(issue_entry_o),       256'(x_entry));
    if (eack   >= 0) chk("fixed_ack",   256'(decoded_ack_o),       256'(eack));
    if (evalid >= 0) chk("fixed_valid", 256'(issue_entry_valid_o), 256'(evalid));
    if (efill  >= 0) chk("fixed_fill",  256'(fill_count_o),        256'(efill));
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  initial begin
    //           fl dbg v cf csr ack  eack evalid efill
    tbl[0]  = '{0, 0, 1, 0, 0, 0,  1, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 0,  1, 1, 1};
    tbl[2]  = '{0, 0, 1, 0, 0, 0,  1, 1, 2};
    tbl[3]  = '{0, 0, 1, 0, 0, 0,  1, 1, 3};
    tbl[4]  = '{0, 0, 1, 0, 0, 1,  0, 1, 4};  // full + pop: no accept
    tbl[5]  = '{0, 0, 1, 0, 0, 0,  1, 1, 3};
    tbl[6]  = '{0, 0, 0, 0, 0, 0,  0, 1, 4};
    tbl[7]  = '{1, 0, 1, 0, 0, 1,  0, 0, 4};  // flush cycle
    tbl[8]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0};
    tbl[9]  = '{0, 0, 1, 1, 0, 0,  1, 0, 0};  // first branch
    tbl[10] = '{0, 0, 1, 1, 0, 0,  0, 1, 1};  // cap reached
    tbl[11] = '{0, 0, 1, 1, 0, 1,  0, 1, 1};  // pop, still no accept
    tbl[12] = '{0, 0, 1, 1, 0, 0,  1, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 1,  0, 1, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 0,  0, 0, 0};

    step(0, 0, 0, 1, 0, mk(ALU, 64'h1), 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, mk(ALU, 64'h2), 1, 0, 0, 0);

    for (int i = 0; i < 15; i++)
      step(1, tbl[i].fl, tbl[i].dbg, tbl[i].v, tbl[i].cf,
           mk(tbl[i].csr ? CSR : (tbl[i].cf ? CTRL_FLOW : ALU), 64'(i)),
           tbl[i].ack, tbl[i].eack, tbl[i].evalid, tbl[i].efill);

    // Streaming with pointer wrap
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 1, 0, mk(ALU, 64'(100 + i)), 1, 1, (i > 0) ? 1 : 0, (i > 0) ? 1 : 0);
    step(1, 0, 0, 0, 0, mk(ALU, 64'd0), 1, 0, 1, 1);

    // CSR serialisation
    step(1, 0, 0, 1, 0, mk(ALU, 64'd200), 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, mk(ALU, 64'd201), 0, 1, 1, 1);
    step(1, 0, 0, 1, 0, mk(CSR, 64'd202), 0, 0, 1, 2);
    step(1, 0, 0, 1, 0, mk(CSR, 64'd202), 1, 0, 1, 2);
    step(1, 0, 0, 1, 0, mk(CSR, 64'd202), 1, 0, 1, 1);
    step(1, 0, 0, 1, 0, mk(CSR, 64'd202), 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, mk(ALU, 64'd203), 0, 0, 1, 1);
    step(1, 0, 0, 1, 0, mk(ALU, 64'd203), 1, 0, 1, 1);
    step(1, 0, 0, 1, 0, mk(ALU, 64'd203), 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, mk(ALU, 64'd0),   1, 0, 1, 1);

    // Debug halt: drains, no accepts until flush
    step(1, 0, 0, 1, 0, mk(ALU, 64'd300), 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, mk(ALU, 64'd301), 0, 1, 1, 1);
    step(1, 0, 1, 0, 0, mk(ALU, 64'd302), 0, 0, 1, 2);
    step(1, 0, 0, 1, 0, mk(ALU, 64'd302), 1, 0, 1, 2);
    step(1, 0, 0, 1, 0, mk(ALU, 64'd302), 1, 0, 1, 1);
    step(1, 0, 0, 1, 0, mk(ALU, 64'd302), 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, mk(ALU, 64'd302), 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, mk(ALU, 64'd303), 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, mk(ALU, 64'd0),   1, 0, 1, 1);
    // debug rising edge still admits the entry presented that cycle
    step(1, 0, 1, 1, 0, mk(ALU, 64'd310), 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, mk(ALU, 64'd311), 1, 0, 1, 1);
    step(1, 1, 0, 0, 0, mk(ALU, 64'd0),   0, 0, 0, 0);

    // Reset mid-stream
    step(1, 0, 0, 1, 1, mk(CTRL_FLOW, 64'd400), 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, mk(ALU, 64'd401),       0, 1, 1, 1);
    step(1, 0, 0, 1, 0, mk(ALU, 64'd402),       0, 1, 1, 2);
    step(0, 0, 0, 1, 0, mk(ALU, 64'd403),       1, 0, 0, 0);
    step(1, 0, 0, 0, 0, mk(ALU, 64'd0),         0, 0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int   pick;
      fu_t  fu;
      bit   cf;
      pick = $urandom_range(0, 99);
      if (pick < 10)      fu = CSR;
      else if (pick < 30) fu = CTRL_FLOW;
      else if (pick < 45) fu = LOAD;
      else                fu = ALU;
      cf = (fu == CTRL_FLOW);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1,
           $urandom_range(0, 99) < 70, cf, mk(fu, 64'(1000 + i)), $urandom_range(0, 99) < 50,
           -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decoded_instr_queue.md
# decoded_instr_queue

Producer-side buffer for the decoded-instruction → issue handshake. It accepts scoreboard entries from the ID stage and presents them to the issue stage using the valid/ack protocol: `valid` is held until `ack`, and an entry is consumed in any cycle where both are high. It also enforces three issue-side policies: a cap on in-flight control-flow entries, CSR serialisation, and a debug halt.

## Interface
Parameters:
- DEPTH, 4, number of entry slots; power of two, ≥2.
- MAX_CF, 1, maximum control-flow entries held at once; 1..DEPTH.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- flush_i  in  1  discard all held entries.
- debug_req_i  in  1  debug request; stop accepting new entries.
- decoded_entry_i  in  $bits(ariane_pkg::scoreboard_entry_t)  decoded entry from ID.
- decoded_valid_i  in  1  decoded_entry_i valid.
- decoded_is_ctrl_flow_i  in  1  entry is a control-flow instruction.
- decoded_ack_o  out  1  entry accepted this cycle.
- issue_entry_o  out  $bits(ariane_pkg::scoreboard_entry_t)  head entry.
- issue_entry_valid_o  out  1  head entry valid.
- is_ctrl_flow_o  out  1  head entry is control flow.
- issue_instr_ack_i  in  1  issue consumed the head this cycle.
- fill_count_o  out  $clog2(DEPTH)+1  number of held entries.

## Operation
- Storage is a circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus count (0..DEPTH) and cf_count (0..MAX_CF).
- Each slot stores the entry and its is_ctrl_flow bit.
- push = decoded_ack_o. The ack is combinational: decoded_ack_o = decoded_valid_i & !flush_i & state==RUN & count<DEPTH & accept-rule.
- Accept rules:
  - Control-flow entry: requires cf_count<MAX_CF.
  - Entry with fu==CSR: requires count==0.
- decoded_ack_o never depends on issue_instr_ack_i. A full queue therefore does not accept, even when a pop happens in the same cycle.
- pop = issue_entry_valid_o & issue_instr_ack_i.
- Outputs:
  - issue_entry_valid_o = count!=0 & !flush_i.
  - issue_entry_o and is_ctrl_flow_o come from slot[rd_ptr], forced to '0 when count==0.
- Counters:
  - count += push − pop.
  - cf_count += (push & ctrl) − (pop & head ctrl).
  - A simultaneous push and pop leaves each counter unchanged.
- States:
  - RUN: normal operation.
    - Accepting a CSR entry goes to SERIAL.
    - debug_req_i high goes to HALT. debug_req_i takes priority, and the ack is already 0 in that cycle only if debug_req_i was registered; see Timing.
  - SERIAL: no accepts. Popping the CSR entry, identified as the head with fu==CSR, returns to RUN. If debug_req_i is high that cycle, go to HALT instead.
  - HALT: no accepts. The queue keeps draining to issue. Only flush_i or reset leaves HALT, returning to RUN.
- flush_i:
  - Same cycle: decoded_ack_o=0 and issue_entry_valid_o=0, so no push or pop occurs.
  - Next edge: pointers, count and cf_count become 0, and state becomes RUN.
  - Flush overrides debug_req_i in the same cycle.
- Reset (rst_ni low at an edge): the same clear as flush, state=RUN, and slot contents are zeroed. During reset cycles all outputs are forced to 0.

## Timing
- Latency: an entry pushed at edge N is presented at issue_entry_o from cycle N+1. There is no bypass path.
- Throughput: one push and one pop per cycle.
- debug_req_i is sampled at the edge. The transition to HALT takes effect the following cycle, so a push may still occur in the same cycle debug_req_i first rises.
- Reset values: issue_entry_valid_o=0, is_ctrl_flow_o=0, issue_entry_o='0, decoded_ack_o=0, fill_count_o=0.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble.
- Full (count==DEPTH): decoded_ack_o=0. Outputs are still valid.
- Empty (count==0): issue_entry_valid_o=0. issue_instr_ack_i is ignored.
- Reset or flush mid-transfer: any entry not popped before the edge is lost. The producer must re-present it.

## Test plan
- Streaming: push 8 ALU entries with issue_instr_ack_i=1 (DEPTH=4) → each entry appears one cycle after its push, in order; fill_count_o stays ≤1; pointers wrap once.
- Full with simultaneous pop: fill 4 entries with issue_instr_ack_i=0, then present a 5th entry with issue_instr_ack_i=1 → decoded_ack_o=0 that cycle and fill_count_o=3; the 5th is accepted next cycle and fill_count_o=4.
- Control-flow cap (MAX_CF=1): push a branch, then present a second branch → second not acked until the first is popped; it is accepted in the cycle after that pop.
- CSR serialisation: present a CSR entry with 2 ALU entries queued → acked only once fill_count_o=0; the state then blocks further accepts until the CSR is popped, after which an ALU entry is acked the next cycle.
- Debug halt: raise debug_req_i with 2 entries queued → no further acks; both entries drain; acks resume only after a flush_i pulse.
- Flush and reset: with 3 entries queued, pulse flush_i → that cycle issue_entry_valid_o=0 and decoded_ack_o=0; next cycle fill_count_o=0. Repeat with rst_ni low for 1 cycle → identical cleared state and all outputs 0.
